viterbi_decoder_k7: RTL and testbench

// - Hard-decision Viterbi decoder for the 802.11a K=7 code (g0=133o -> InA, g1=171o -> InB), rate 1/2.
// - Parametrised successor to the fixed-length BPMC/traceback decoder: streaming, register-exchange survivors,

---
 rtl/viterbi_decoder_k7.sv | 179 +++++++++++++++++
 tb/tb_viterbi_decoder_k7.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decoder_k7.sv
// Streaming hard-decision Viterbi decoder for the 802.11a K=7 rate-1/2 code, register-exchange survivors.
// Optional macro ERASURE_EN adds i_in_erase so depunctured (rate 2/3, 3/4) streams can mark missing bits.
module viterbi_decoder_k7 #(
  parameter int TB_DEPTH = 42,
  parameter int PM_WIDTH = 8
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_in_a,
  input  logic       i_in_b,
  input  logic       i_in_valid,
  output logic       o_in_ready,
`ifdef ERASURE_EN
  input  logic [1:0] i_in_erase,
`endif
  input  logic       i_flush,
  output logic       o_output,
  output logic       o_out_valid,
  output logic       o_done
);
  localparam int NS = 64;
  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam logic [PM_WIDTH-1:0] PM_INIT = {2'b01, {(PM_WIDTH-2){1'b0}}};
  localparam logic [CW-1:0] CNT_FULL = CW'(TB_DEPTH);
  localparam logic [CW-1:0] CNT_TAIL = CW'(TB_DEPTH - 1);

  // IDLE: waiting for first pair | RUN: decoding, emitting once full | DRAIN: flushing survivor[0]
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic [PM_WIDTH-1:0] r_pm   [NS];
  logic [TB_DEPTH-1:0] r_surv [NS];
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_drain_left;
  logic                r_output;
  logic                r_out_valid;
  logic                r_done;

  logic [PM_WIDTH-1:0] w_c0       [NS];
  logic [PM_WIDTH-1:0] w_c1       [NS];
  logic [PM_WIDTH-1:0] w_pm_acs   [NS];
  logic [PM_WIDTH-1:0] w_pm_new   [NS];
  logic [TB_DEPTH-1:0] w_surv_new [NS];
  logic                w_norm;
  logic [PM_WIDTH-1:0] w_best_pm;
  logic [5:0]          w_best;
  logic                w_best_bit;
  logic                w_erase_a;
  logic                w_erase_b;
  logic                w_accept;
  logic [CW-1:0]       w_count_inc;
  logic [CW-1:0]       w_count_end;
  logic [CW-1:0]       w_drain_init;

`ifdef ERASURE_EN
  assign w_erase_a = i_in_erase[1];
  assign w_erase_b = i_in_erase[0];
`else
  assign w_erase_a = 1'b0;
  assign w_erase_b = 1'b0;
`endif

  function automatic logic [1:0] branch_metric(input logic [5:0] p, input logic b,
                                               input logic ia, input logic ib,
                                               input logic ea, input logic eb);
    logic xa;
    logic xb;
    xa = b ^ p[4] ^ p[3] ^ p[1] ^ p[0];
    xb = b ^ p[5] ^ p[4] ^ p[3] ^ p[0];
    return {1'b0, (ia ^ xa) & ~ea} + {1'b0, (ib ^ xb) & ~eb};
  endfunction

  function automatic logic [PM_WIDTH-1:0] sat_add(input logic [PM_WIDTH-1:0] pm, input logic [1:0] bm);
    logic [PM_WIDTH:0] sum;
    sum = {1'b0, pm} + {{(PM_WIDTH-1){1'b0}}, bm};
    return sum[PM_WIDTH] ? '1 : sum[PM_WIDTH-1:0];
  endfunction

  // Predecessors of s are {s[4:0],0} and {s[4:0],1}; ties resolve toward the even one.
  always_comb begin
    w_norm = 1'b1;
    for (int s = 0; s < NS; s++) begin
      w_c0[s] = sat_add(r_pm[(2*s) % NS],
                        branch_metric(6'((2*s) % NS), s >= 32, i_in_a, i_in_b, w_erase_a, w_erase_b));
      w_c1[s] = sat_add(r_pm[(2*s+1) % NS],
                        branch_metric(6'((2*s+1) % NS), s >= 32, i_in_a, i_in_b, w_erase_a, w_erase_b));
      if (w_c0[s] <= w_c1[s]) begin
        w_pm_acs[s]   = w_c0[s];
        w_surv_new[s] = {r_surv[(2*s) % NS][TB_DEPTH-2:0], s >= 32};
      end else begin
        w_pm_acs[s]   = w_c1[s];
        w_surv_new[s] = {r_surv[(2*s+1) % NS][TB_DEPTH-2:0], s >= 32};
      end
      w_norm = w_norm & w_pm_acs[s][PM_WIDTH-1];
    end
    for (int s = 0; s < NS; s++) begin
      w_pm_new[s] = w_norm ? {1'b0, w_pm_acs[s][PM_WIDTH-2:0]} : w_pm_acs[s];
    end
  end

  always_comb begin
    w_best_pm = w_pm_acs[0];
    w_best    = 6'd0;
    for (int s = 1; s < NS; s++) begin
      if (w_pm_acs[s] < w_best_pm) begin
        w_best_pm = w_pm_acs[s];
        w_best    = 6'(s);
      end
    end
    w_best_bit = w_surv_new[w_best][TB_DEPTH-1];
  end

  assign o_in_ready   = (r_state != S_DRAIN);
  assign w_accept     = i_in_valid && o_in_ready;
  assign w_count_inc  = (r_count == CNT_FULL) ? r_count : r_count + 1'b1;
  assign w_count_end  = w_accept ? w_count_inc : r_count;
  // Bits still held in the survivor when the packet ends; RUN already emitted the rest.
  assign w_drain_init = (w_count_end == CNT_FULL) ? CNT_TAIL : w_count_end;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_drain_left <= '0;
      r_output     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
      for (int s = 0; s < NS; s++) begin
        r_pm[s]   <= (s == 0) ? '0 : PM_INIT;
        r_surv[s] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN: begin
          if (w_accept) begin
            for (int s = 0; s < NS; s++) begin
              r_pm[s]   <= w_pm_new[s];
              r_surv[s] <= w_surv_new[s];
            end
            r_count <= w_count_inc;
            if (w_count_inc == CNT_FULL) begin
              r_out_valid <= 1'b1;
              r_output    <= w_best_bit;
            end
          end
          if (r_state == S_IDLE) begin
            if (w_accept) r_state <= S_RUN;
          end else if (i_flush) begin
            r_state      <= S_DRAIN;
            r_drain_left <= w_drain_init;
          end
        end
        S_DRAIN: begin
          if (r_drain_left != '0) begin
            r_out_valid  <= 1'b1;
            r_output     <= r_surv[0][r_drain_left - 1'b1];
            r_drain_left <= r_drain_left - 1'b1;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            r_count <= '0;
            for (int s = 0; s < NS; s++) begin
              r_pm[s]   <= (s == 0) ? '0 : PM_INIT;
              r_surv[s] <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_output    = r_output;
  assign o_out_valid = r_out_valid;
  assign o_done      = r_done;

endmodule

// File: tb/tb_viterbi_decoder_k7.sv
// Directed bench for viterbi_decoder_k7: encodes known bit streams, optionally corrupts them,
// and checks decoded bits, output timing, Done timing and reset behaviour.
module tb_viterbi_decoder_k7;
  localparam int TB_DEPTH = 42;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_a = 1'b0;
  logic in_b = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic ready;
  logic dout;
  logic dvalid;
  logic done;
`ifdef ERASURE_EN
  logic [1:0] erase = 2'b00;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit   src[$];
  bit   ea[$];
  bit   eb[$];
  logic [1:0] ers[$];
  bit   out_q[$];
  int   out_cyc[$];
  int   acc_cyc[$];
  int   done_cnt = 0;
  int   done_cyc = -1;
  logic ready_after_flush;

  viterbi_decoder_k7 #(.TB_DEPTH(TB_DEPTH), .PM_WIDTH(8)) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_in_a     (in_a),
    .i_in_b     (in_b),
    .i_in_valid (in_valid),
    .o_in_ready (ready),
`ifdef ERASURE_EN
    .i_in_erase (erase),
`endif
    .i_flush    (flush),
    .o_output   (dout),
    .o_out_valid(dvalid),
    .o_done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dvalid) begin
      out_q.push_back(dout);
      out_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic load_src(input logic [41:0] d);
    src.delete();
    for (int i = 0; i < 42; i++) src.push_back(d[i]);
    for (int i = 0; i < 6; i++) src.push_back(1'b0);
  endtask

  // Reference K=7 encoder (133o/171o), newest input in sr[5]; flips bit A of selected pairs.
  task automatic encode(input int flip_period, input int flip_off);
    logic [5:0] sr;
    bit b;
    bit xa;
    bit xb;
    sr = 6'd0;
    ea.delete(); eb.delete(); ers.delete();
    for (int k = 0; k < src.size(); k++) begin
      b  = src[k];
      xa = b ^ sr[4] ^ sr[3] ^ sr[1] ^ sr[0];
      xb = b ^ sr[5] ^ sr[4] ^ sr[3] ^ sr[0];
      sr = {b, sr[5:1]};
      if (flip_period > 0 && (k % flip_period) == flip_off) xa = ~xa;
      ea.push_back(xa);
      eb.push_back(xb);
      ers.push_back(2'b00);
    end
  endtask

  task automatic run_packet(input int n_send, input bit do_flush, output bit timed_out);
    timed_out = 1'b0;
    out_q.delete(); out_cyc.delete(); acc_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    for (int k = 0; k < n_send; k++) begin
      in_a = ea[k];
      in_b = eb[k];
`ifdef ERASURE_EN
      erase = ers[k];
`endif
      in_valid = 1'b1;
      flush = do_flush && (k == n_send - 1);
      @(posedge clk); #1;
      acc_cyc.push_back(cyc);
    end
    in_valid = 1'b0;
    flush = 1'b0;
`ifdef ERASURE_EN
    erase = 2'b00;
`endif
    ready_after_flush = ready;
    if (do_flush) begin
      timed_out = 1'b1;
      for (int w = 0; w < 300; w++) begin
        @(negedge clk); #1;
        if (done_cnt > 0) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
  endtask

  function automatic int bit_errors();
    int e;
    e = 0;
    for (int i = 0; i < out_q.size() && i < src.size(); i++)
      if (out_q[i] !== src[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if (dvalid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", dvalid); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (dout !== 1'b0) begin n_bad++; $display("FAIL reset_output: got %b expected 0", dout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_packet();
    bit to;
    int e;
    load_src(42'h2D9_A6C3_B17E);
    encode(0, 0);
    run_packet(48, 1'b1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL clean_timeout: got %b expected 0", to); end
    n_cmp++; if (ready_after_flush !== 1'b0) begin n_bad++; $display("FAIL clean_ready_in_drain: got %b expected 0", ready_after_flush); end
    n_cmp++; if (out_q.size() != 48) begin n_bad++; $display("FAIL clean_count: got %0d expected 48", out_q.size()); end
    e = bit_errors();
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL clean_bits: got %0d bit errors expected 0", e); end
    if (out_cyc.size() > 0) begin
      n_cmp++;
      if (out_cyc[0] != acc_cyc[TB_DEPTH-1]) begin
        n_bad++; $display("FAIL clean_latency: got cycle %0d expected %0d", out_cyc[0], acc_cyc[TB_DEPTH-1]);
      end
      n_cmp++;
      if (done_cyc != out_cyc[out_cyc.size()-1] + 1) begin
        n_bad++; $display("FAIL clean_done_time: got cycle %0d expected %0d", done_cyc, out_cyc[out_cyc.size()-1] + 1);
      end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL clean_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_bit_errors();
    bit to;
    int e;
    load_src(42'h2D9_A6C3_B17E);
    encode(12, 5);
    run_packet(48, 1'b1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL err_timeout: got %b expected 0", to); end
    n_cmp++; if (out_q.size() != 48) begin n_bad++; $display("FAIL err_count: got %0d expected 48", out_q.size()); end
    e = bit_errors();
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL err_bits: got %0d bit errors expected 0", e); end
  endtask

  task automatic test_short_packet();
    bit to;
    int e;
    src.delete();
    src.push_back(1'b1); src.push_back(1'b1);
    for (int i = 0; i < 6; i++) src.push_back(1'b0);
    encode(0, 0);
    run_packet(8, 1'b1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL short_timeout: got %b expected 0", to); end
    n_cmp++; if (out_q.size() != 8) begin n_bad++; $display("FAIL short_count: got %0d expected 8", out_q.size()); end
    e = bit_errors();
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL short_bits: got %0d bit errors expected 0", e); end
    if (out_cyc.size() > 0) begin
      n_cmp++;
      if (out_cyc[0] != acc_cyc[7] + 1) begin
        n_bad++; $display("FAIL short_first_in_drain: got cycle %0d expected %0d", out_cyc[0], acc_cyc[7] + 1);
      end
      n_cmp++;
      if (done_cyc != out_cyc[out_cyc.size()-1] + 1) begin
        n_bad++; $display("FAIL short_done_time: got cycle %0d expected %0d", done_cyc, out_cyc[out_cyc.size()-1] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int e;
    src.delete();
    src.push_back(1'b0); src.push_back(1'b1); src.push_back(1'b1);
    for (int i = 0; i < 6; i++) src.push_back(1'b0);
    encode(0, 0);
    run_packet(9, 1'b1, to);
    e = bit_errors();
    n_cmp++; if (to !== 1'b0 || out_q.size() != 9) begin n_bad++; $display("FAIL b2b_first_count: got %0d expected 9", out_q.size()); end
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL b2b_first_bits: got %0d bit errors expected 0", e); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_done: got %b expected 1", ready); end
    load_src(42'h1C3_5E0F_96A4);
    encode(0, 0);
    run_packet(48, 1'b1, to);
    e = bit_errors();
    n_cmp++; if (to !== 1'b0 || out_q.size() != 48) begin n_bad++; $display("FAIL b2b_second_count: got %0d expected 48", out_q.size()); end
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL b2b_second_bits: got %0d bit errors expected 0", e); end
  endtask

  task automatic test_long_stream();
    bit to;
    int e;
    src.delete();
    for (int i = 0; i < 3994; i++) src.push_back(1'b1);
    for (int i = 0; i < 6; i++) src.push_back(1'b0);
    encode(12, 7);
    run_packet(4000, 1'b1, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL long_timeout: got %b expected 0", to); end
    n_cmp++; if (out_q.size() != 4000) begin n_bad++; $display("FAIL long_count: got %0d expected 4000", out_q.size()); end
    e = bit_errors();
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL long_bits: got %0d bit errors expected 0", e); end
    if (out_cyc.size() > 0) begin
      n_cmp++;
      if (out_cyc[0] != acc_cyc[TB_DEPTH-1]) begin
        n_bad++; $display("FAIL long_latency: got cycle %0d expected %0d", out_cyc[0], acc_cyc[TB_DEPTH-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int e;
    load_src(42'h3A0_F5C2_6D19);
    encode(0, 0);
    run_packet(20, 1'b0, to);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b expected 0", dvalid); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b expected 0", done); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b expected 1", ready); end
    repeat (2) @(negedge clk);
    n_cmp++; if (out_q.size() != 0 || done_cnt != 0) begin n_bad++; $display("FAIL midrst_no_output: got %0d bits %0d done expected 0 0", out_q.size(), done_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    run_packet(48, 1'b1, to);
    e = bit_errors();
    n_cmp++; if (to !== 1'b0 || out_q.size() != 48) begin n_bad++; $display("FAIL midrst_fresh_count: got %0d expected 48", out_q.size()); end
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL midrst_fresh_bits: got %0d bit errors expected 0", e); end
  endtask

`ifdef ERASURE_EN
  task automatic test_erasure();
    bit to;
    int e;
    load_src(42'h2D9_A6C3_B17E);
    encode(24, 3);
    // Rate-3/4 puncturing: pair%3==1 drops B, pair%3==2 drops A; dropped slots carry wrong bits.
    for (int k = 0; k < ea.size(); k++) begin
      if (k % 3 == 1) begin ers[k] = 2'b01; eb[k] = ~eb[k]; end
      if (k % 3 == 2) begin ers[k] = 2'b10; ea[k] = ~ea[k]; end
    end
    run_packet(48, 1'b1, to);
    e = bit_errors();
    n_cmp++; if (to !== 1'b0 || out_q.size() != 48) begin n_bad++; $display("FAIL erase_count: got %0d expected 48", out_q.size()); end
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL erase_bits: got %0d bit errors expected 0", e); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_packet();
    test_bit_errors();
    test_short_packet();
    test_back_to_back();
    test_long_stream();
    test_reset_mid();
`ifdef ERASURE_EN
    test_erasure();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
